dsp_file_server: RTL and testbench

Responder end of the DSP file-access handshake. The block holds `NUM_FILES` independent circular word buffers ("files") in one shared RAM and services read and write requests issued on `file_num`/`file_read`/`file_write` by DSP equation engines and loaders. It returns data on `file_read_data` with a fixed `file_active` pulse, and publishes the selected file's read and write pointers so requesters can detect end-of-data (`wr_ptr == rd_ptr`). It sits between the DSP slave register block and the equation engines.

---
 rtl/dsp_file_server_pkg.sv | 19 +
 rtl/dsp_file_server_if.sv | 28 ++
 rtl/dsp_file_server_ram.sv | 19 +
 rtl/dsp_file_server.sv | 152 +++++++++++++++
 tb/tb_dsp_file_server.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_file_server_pkg.sv
// Shared definitions for the DSP file server: FSM encoding, default
// geometry and the pointer-width helper.
package dsp_file_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DATA   = 2'd2
    } state_e;

    localparam int DEF_NUM_FILES = 4;
    localparam int DEF_DEPTH     = 256;

    // Pointer carries one extra wrap bit above the RAM word index.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dsp_file_server_if.sv
// Requester <-> file server handshake bundle.
interface dsp_file_server_if #(
    parameter int dw = 32
);
    logic [7:0]    file_num;
    logic          file_read;
    logic          file_write;
    logic [dw-1:0] file_write_data;
    logic          file_clear;
    logic          err_clear;
    logic [dw-1:0] file_read_data;
    logic          file_active;
    logic [31:0]   rd_ptr;
    logic [31:0]   wr_ptr;
    logic          error;

    modport slave (
        input  file_num, file_read, file_write, file_write_data,
               file_clear, err_clear,
        output file_read_data, file_active, rd_ptr, wr_ptr, error
    );

    modport master (
        output file_num, file_read, file_write, file_write_data,
               file_clear, err_clear,
        input  file_read_data, file_active, rd_ptr, wr_ptr, error
    );
endinterface

// File: rtl/dsp_file_server_ram.sv
// Single-port synchronous RAM backing all files; one-cycle read latency.
module dsp_file_ram #(
    parameter int dw = 32,
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [dw-1:0] wdata_i,
    output logic [dw-1:0] rdata_o
);
    logic [dw-1:0] mem_q [2**AW];

    // Registered read, optional write on the same port.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/dsp_file_server.sv
// DSP file server: NUM_FILES circular buffers in one RAM, serviced by a
// three-state IDLE/ACCESS/DATA handshake with a fixed 2-cycle active pulse.
module dsp_file_server
    import dsp_file_pkg::*;
#(
    parameter int dw        = 32,
    parameter int NUM_FILES = DEF_NUM_FILES,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    dsp_file_server_if.slave bus
);
    localparam int FW  = $clog2(NUM_FILES);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = ptr_w(DEPTH);
    localparam int RAW = FW + AW;
    localparam logic [8:0] NF9 = 9'(NUM_FILES);

    state_e        state_q, state_d;
    logic          op_rd_q, op_rd_d;
    logic [7:0]    fnum_q, fnum_d;
    logic [dw-1:0] wdata_q, wdata_d;
    logic [dw-1:0] rdata_q, rdata_d;
    logic          fault_q, fault_d;
    logic          error_q, error_d;

    logic [PW-1:0] rd_ptr_q [NUM_FILES];
    logic [PW-1:0] wr_ptr_q [NUM_FILES];

    logic          live_ok, sel_ok, sel_empty, sel_full, acc_fault;
    logic [FW-1:0] live_idx, sel_idx;
    logic          clr_en, inc_rd, inc_wr;
    logic          ram_we;
    logic [RAW-1:0] ram_addr;
    logic [dw-1:0] ram_rdata;

    assign live_ok  = ({1'b0, bus.file_num} < NF9);
    assign live_idx = bus.file_num[FW-1:0];
    assign sel_ok   = ({1'b0, fnum_q} < NF9);
    assign sel_idx  = fnum_q[FW-1:0];

    assign sel_empty = (rd_ptr_q[sel_idx] == wr_ptr_q[sel_idx]);
    assign sel_full  = (rd_ptr_q[sel_idx][PW-1] != wr_ptr_q[sel_idx][PW-1]) &&
                       (rd_ptr_q[sel_idx][AW-1:0] == wr_ptr_q[sel_idx][AW-1:0]);
    assign acc_fault = !sel_ok || (op_rd_q ? sel_empty : sel_full);

    // In IDLE the port follows the live read address so the word is already
    // in the RAM output register during ACCESS; this lets file_read_data be
    // loaded on entry to DATA, while file_active is still high.
    // Pointers cannot move between acceptance and ACCESS (clear is IDLE-only).
    always_comb begin
        ram_addr = {live_idx, rd_ptr_q[live_idx][AW-1:0]};
        if (state_q == ST_ACCESS) ram_addr = {sel_idx, wr_ptr_q[sel_idx][AW-1:0]};
    end
    assign ram_we = (state_q == ST_ACCESS) && !op_rd_q && !acc_fault;

    dsp_file_ram #(.dw(dw), .AW(RAW)) u_ram (
        .clk_i   (wb_clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Next-state, capture and pointer-control decode.
    always_comb begin
        state_d = state_q;
        op_rd_d = op_rd_q;
        fnum_d  = fnum_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        error_d = error_q;
        clr_en  = 1'b0;
        inc_rd  = 1'b0;
        inc_wr  = 1'b0;
        if (bus.err_clear) error_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A clear takes the cycle; a pending request is taken next cycle.
                if (bus.file_clear) begin
                    clr_en = live_ok;
                end else if (bus.file_read || bus.file_write) begin
                    state_d = ST_ACCESS;
                    op_rd_d = bus.file_read;
                    fnum_d  = bus.file_num;
                    wdata_d = bus.file_write_data;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DATA;
                fault_d = acc_fault;
                if (acc_fault) error_d = 1'b1;
                if (op_rd_q) rdata_d = acc_fault ? '0 : ram_rdata;
            end
            ST_DATA: begin
                state_d = ST_IDLE;
                if (!fault_q) begin
                    inc_rd = op_rd_q;
                    inc_wr = !op_rd_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and transaction capture registers.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            op_rd_q <= 1'b0;
            fnum_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_rd_q <= op_rd_d;
            fnum_q  <= fnum_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            error_q <= error_d;
        end
    end

    // Per-file pointers; increment rolls over naturally at 2*DEPTH.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int i = 0; i < NUM_FILES; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                rd_ptr_q[live_idx] <= '0;
                wr_ptr_q[live_idx] <= '0;
            end
            if (inc_rd) rd_ptr_q[sel_idx] <= rd_ptr_q[sel_idx] + 1'b1;
            if (inc_wr) wr_ptr_q[sel_idx] <= wr_ptr_q[sel_idx] + 1'b1;
        end
    end

    assign bus.file_active    = (state_q != ST_IDLE);
    assign bus.file_read_data = rdata_q;
    assign bus.error          = error_q;
    assign bus.rd_ptr         = live_ok ? 32'(rd_ptr_q[live_idx]) : 32'd0;
    assign bus.wr_ptr         = live_ok ? 32'(wr_ptr_q[live_idx]) : 32'd0;

endmodule

// File: tb/tb_dsp_file_server.sv
// Self-checking bench for dsp_file_server: directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a
// queue-level model of the files.
module tb_dsp_file_server;
    localparam int NF = 4;
    localparam int D  = 256;

    logic wb_clk = 1'b0;
    logic wb_rst_n = 1'b0;
    always #5 wb_clk = ~wb_clk;

    dsp_file_server_if #(.dw(32)) bus ();

    dsp_file_server #(.dw(32), .NUM_FILES(NF), .DEPTH(D)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .bus      (bus)
    );

    int ncmp = 0;
    int nerr = 0;

    // Reference model: occupancy-based view of each circular file.
    int          mrd [NF];
    int          mwr [NF];
    logic [31:0] mmem [NF][D];
    logic        merr;
    logic [31:0] mdata;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  fn;
        logic [31:0] wd;
        logic [31:0] ed;
        int          erp;
        int          ewp;
        bit          eerr;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            mrd[i] = 0;
            mwr[i] = 0;
        end
        merr  = 1'b0;
        mdata = 32'h0;
    endtask

    task automatic model_step(input bit rd, input bit wr, input logic [7:0] fn, input logic [31:0] wd);
        int f;
        int cnt;
        f = int'(fn);
        if (rd) begin
            if (f >= NF || mwr[f] == mrd[f]) begin
                merr  = 1'b1;
                mdata = 32'h0;
            end else begin
                mdata  = mmem[f][mrd[f] % D];
                mrd[f] = (mrd[f] + 1) % (2 * D);
            end
        end else if (wr) begin
            if (f >= NF) begin
                merr = 1'b1;
            end else begin
                cnt = (mwr[f] - mrd[f] + 2 * D) % (2 * D);
                if (cnt == D) begin
                    merr = 1'b1;
                end else begin
                    mmem[f][mwr[f] % D] = wd;
                    mwr[f] = (mwr[f] + 1) % (2 * D);
                end
            end
        end
    endtask

    function automatic int mptr(input bit r, input logic [7:0] fn);
        if (int'(fn) >= NF) return 0;
        return r ? mrd[int'(fn)] : mwr[int'(fn)];
    endfunction

    // One transaction from an IDLE negedge to the negedge after file_active falls.
    task automatic do_txn(input bit rd, input bit wr, input logic [7:0] fn, input logic [31:0] wd,
                          input logic [31:0] ed, input int erp, input int ewp, input bit eerr,
                          input string tag);
        bus.file_read = rd;
        bus.file_write = wr;
        bus.file_num = fn;
        bus.file_write_data = wd;
        @(posedge wb_clk);
        #1;
        bus.file_read = 1'b0;
        bus.file_write = 1'b0;
        @(negedge wb_clk);
        chk({tag, "/active1"}, 32'(bus.file_active), 32'd1);
        @(posedge wb_clk);
        @(negedge wb_clk);
        chk({tag, "/active2"}, 32'(bus.file_active), 32'd1);
        if (rd) chk({tag, "/data"}, bus.file_read_data, ed);
        @(posedge wb_clk);
        @(negedge wb_clk);
        chk({tag, "/active0"}, 32'(bus.file_active), 32'd0);
        chk({tag, "/rd_ptr"}, bus.rd_ptr, 32'(erp));
        chk({tag, "/wr_ptr"}, bus.wr_ptr, 32'(ewp));
        chk({tag, "/error"}, 32'(bus.error), 32'(eerr));
    endtask

    task automatic model_txn(input bit rd, input bit wr, input logic [7:0] fn, input logic [31:0] wd,
                             input string tag);
        model_step(rd, wr, fn, wd);
        do_txn(rd, wr, fn, wd, mdata, mptr(1'b1, fn), mptr(1'b0, fn), merr, tag);
    endtask

    task automatic err_clear_pulse();
        bus.err_clear = 1'b1;
        @(posedge wb_clk);
        #1;
        bus.err_clear = 1'b0;
        merr = 1'b0;
        @(negedge wb_clk);
        chk("err_clear", 32'(bus.error), 32'd0);
    endtask

    initial begin
        logic [31:0] wrap_word;
        bus.file_num = 8'd0;
        bus.file_read = 1'b0;
        bus.file_write = 1'b0;
        bus.file_write_data = 32'h0;
        bus.file_clear = 1'b0;
        bus.err_clear = 1'b0;
        model_reset();

        tbl[0] = '{1'b0, 1'b1, 8'd1, 32'hDEADBEEF, 32'h0,        0, 1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'd1, 32'h00000001, 32'h0,        0, 2, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'd1, 32'h12345678, 32'h0,        0, 3, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 8'd1, 32'h0,        32'hDEADBEEF, 1, 3, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'd1, 32'h0,        32'h00000001, 2, 3, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 8'd1, 32'h0,        32'h12345678, 3, 3, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 8'd2, 32'h0,        32'h0,        0, 0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 8'd9, 32'h0,        32'h0,        0, 0, 1'b1};

        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        chk("rst/active", 32'(bus.file_active), 32'd0);
        chk("rst/data", bus.file_read_data, 32'd0);
        chk("rst/error", 32'(bus.error), 32'd0);
        chk("rst/rd_ptr", bus.rd_ptr, 32'd0);
        chk("rst/wr_ptr", bus.wr_ptr, 32'd0);

        // Directed table: write/read back file 1, empty read, bad file number.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) err_clear_pulse();
            model_step(tbl[i].rd, tbl[i].wr, tbl[i].fn, tbl[i].wd);
            do_txn(tbl[i].rd, tbl[i].wr, tbl[i].fn, tbl[i].wd, tbl[i].ed,
                   tbl[i].erp, tbl[i].ewp, tbl[i].eerr, $sformatf("vec%0d", i));
        end
        bus.file_num = 8'd1;
        #1;
        chk("badfile/rd_ptr1", bus.rd_ptr, 32'd3);
        chk("badfile/wr_ptr1", bus.wr_ptr, 32'd3);
        err_clear_pulse();

        // Fill file 0, overflow once, then wrap the write index.
        for (int i = 0; i < D; i++) model_txn(1'b0, 1'b1, 8'd0, $urandom, "fill");
        model_txn(1'b0, 1'b1, 8'd0, 32'hBAD0BAD0, "overflow");
        chk("full/wr_ptr", bus.wr_ptr, 32'd256);
        chk("full/error", 32'(bus.error), 32'd1);
        err_clear_pulse();
        model_txn(1'b1, 1'b0, 8'd0, 32'h0, "wrap_rd");
        wrap_word = 32'hC0FFEE01;
        model_txn(1'b0, 1'b1, 8'd0, wrap_word, "wrap_wr");
        chk("wrap/wr_ptr", bus.wr_ptr, 32'd257);
        for (int i = 0; i < D; i++) model_txn(1'b1, 1'b0, 8'd0, 32'h0, "drain");
        chk("wrap/idx0_data", bus.file_read_data, wrap_word);

        // Read and write held together: read first, write three cycles later;
        // a clear during the write's ACCESS cycle is ignored.
        model_txn(1'b0, 1'b1, 8'd3, 32'h33330001, "pre3");
        model_step(1'b1, 1'b0, 8'd3, 32'h0);
        model_step(1'b0, 1'b1, 8'd3, 32'h33330002);
        bus.file_num = 8'd3;
        bus.file_write_data = 32'h33330002;
        bus.file_read = 1'b1;
        bus.file_write = 1'b1;
        @(posedge wb_clk);
        #1 bus.file_read = 1'b0;
        @(negedge wb_clk);
        chk("simul/rd_active", 32'(bus.file_active), 32'd1);
        @(negedge wb_clk);
        chk("simul/rd_data", bus.file_read_data, 32'h33330001);
        @(negedge wb_clk);
        chk("simul/gap", 32'(bus.file_active), 32'd0);
        chk("simul/rd_ptr1", bus.rd_ptr, 32'd1);
        chk("simul/wr_ptr1", bus.wr_ptr, 32'd1);
        @(negedge wb_clk);
        chk("simul/wr_active", 32'(bus.file_active), 32'd1);
        bus.file_clear = 1'b1;
        @(negedge wb_clk);
        bus.file_clear = 1'b0;
        bus.file_write = 1'b0;
        @(negedge wb_clk);
        chk("simul/done", 32'(bus.file_active), 32'd0);
        chk("simul/rd_ptr2", bus.rd_ptr, 32'd1);
        chk("simul/wr_ptr2", bus.wr_ptr, 32'd2);

        // Clear in IDLE, then clear coinciding with a write request.
        bus.file_clear = 1'b1;
        @(posedge wb_clk);
        #1 bus.file_clear = 1'b0;
        @(negedge wb_clk);
        mrd[3] = 0;
        mwr[3] = 0;
        chk("clear/rd_ptr", bus.rd_ptr, 32'd0);
        chk("clear/wr_ptr", bus.wr_ptr, 32'd0);
        bus.file_clear = 1'b1;
        bus.file_write = 1'b1;
        bus.file_write_data = 32'hA5A5A5A5;
        @(posedge wb_clk);
        #1 bus.file_clear = 1'b0;
        @(negedge wb_clk);
        chk("clrreq/not_yet", 32'(bus.file_active), 32'd0);
        @(posedge wb_clk);
        #1 bus.file_write = 1'b0;
        model_step(1'b0, 1'b1, 8'd3, 32'hA5A5A5A5);
        @(negedge wb_clk);
        chk("clrreq/active", 32'(bus.file_active), 32'd1);
        repeat (2) @(negedge wb_clk);
        chk("clrreq/done", 32'(bus.file_active), 32'd0);
        chk("clrreq/wr_ptr", bus.wr_ptr, 32'd1);
        chk("clrreq/rd_ptr", bus.rd_ptr, 32'd0);

        // Asynchronous reset in the middle of a transaction.
        bus.file_num = 8'd2;
        bus.file_write = 1'b1;
        bus.file_write_data = 32'h22220000;
        @(posedge wb_clk);
        #2 wb_rst_n = 1'b0;
        #1;
        chk("midrst/active", 32'(bus.file_active), 32'd0);
        chk("midrst/wr_ptr2", bus.wr_ptr, 32'd0);
        bus.file_write = 1'b0;
        bus.file_num = 8'd3;
        #1;
        chk("midrst/wr_ptr3", bus.wr_ptr, 32'd0);
        model_reset();
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        model_txn(1'b0, 1'b1, 8'd2, 32'h22221111, "post_rst_wr");
        model_txn(1'b1, 1'b0, 8'd2, 32'h0, "post_rst_rd");

        // Randomized traffic, including bad file numbers and empty reads.
        for (int i = 0; i < 120; i++) begin
            bit op;
            logic [7:0] fn;
            op = 1'($urandom_range(0, 1));
            fn = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) err_clear_pulse();
            model_txn(op, !op, fn, $urandom, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
